// File: rtl/v810_bus_ram.sv
// V810 external-bus slave RAM: run-time wait states, 32/16-bit dynamic sizing, preload port.
// Optional range check is enabled by defining V810_BUS_RAM_RANGECHK_EN.
module v810_bus_ram #(
   parameter int          AW        = 10,
   parameter int          WSW       = 3,
   parameter logic        BUS16_RST = 1'b0
) (
   input  logic           CLK,
   input  logic           RESn,
   input  logic           CE,
   input  logic [31:0]    A,
   input  logic [31:0]    D_I,
   output logic [31:0]    D_O,
   input  logic [3:0]     BEn,
   input  logic           DAn,
   input  logic           MRQn,
   input  logic           RW,
   input  logic           BCYSTn,
   output logic           READYn,
   output logic           SZRQn,
   input  logic [WSW-1:0] WS,
   input  logic           BUS16_SET,
   input  logic           BUS16_VAL,
   input  logic           PWE,
   input  logic [AW-1:0]  PA,
   input  logic [31:0]    PD_I,
   output logic [31:0]    PD_O,
   output logic           ERR
);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t          r_state;
   logic [WSW-1:0]  r_cnt;
   logic            r_bus16;
   logic [15:0]     r_bcy_cnt;
   logic [31:0]     r_mem [2**AW];

   logic            w_act;
   logic            w_rdy;
   logic            w_oor;
   logic            w_lo;
   logic            w_wr;
   logic            w_pwe;
   logic            w_idle_free;
   logic [AW-1:0]   w_idx;
   logic [31:0]     w_word;
   logic [15:0]     w_half;
   logic [3:0]      w_wbe;
   logic [31:0]     w_wdat;
   logic            w_unused;

   assign w_act  = ~MRQn & ~DAn;
   assign w_idx  = A[AW+1:2];
   assign w_word = r_mem[w_idx];

   // Ready is combinational so a zero-wait access completes in its first cycle.
   always_comb begin
      w_rdy = 1'b0;
      if (RESn && w_act) begin
         unique case (r_state)
            S_IDLE:  w_rdy = (WS == '0);
            S_WAIT:  w_rdy = (r_cnt == '0);
            default: w_rdy = 1'b0;
         endcase
      end
   end

   assign READYn = ~w_rdy;
   assign SZRQn  = r_bus16 ? ~w_rdy : 1'b1;

   assign w_lo = (BEn == 4'b1110) || (BEn == 4'b1101) ||
                 (BEn == 4'b1100) || (BEn == 4'b0000);

   assign w_half = w_lo ? w_word[15:0] : w_word[31:16];

`ifdef V810_BUS_RAM_RANGECHK_EN
   assign w_oor    = |A[31:AW+2];
   assign w_unused = &{1'b0, A[1:0], r_bcy_cnt};
`else
   assign w_oor    = 1'b0;
   assign w_unused = &{1'b0, A[1:0], A[31:AW+2], r_bcy_cnt};
`endif

   always_comb begin
      D_O = 32'h0;
      if (w_act && RW) begin
         if (w_oor)
            D_O = r_bus16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
         else if (r_bus16)
            D_O = {16'h0, w_half};
         else
            D_O = w_word;
      end
   end

   // A 16-bit port always carries its data on D[15:0], whichever half is addressed.
   always_comb begin
      w_wbe  = ~BEn;
      w_wdat = D_I;
      if (r_bus16) begin
         w_wdat = {D_I[15:0], D_I[15:0]};
         if (w_lo)
            w_wbe = {2'b00, ~BEn[1:0]};
         else
            w_wbe = {~BEn[3:2], 2'b00};
      end
   end

   assign w_idle_free = (r_state == S_IDLE) && !w_act;
   assign w_wr        = w_rdy && !RW && !w_oor;
   assign w_pwe       = PWE && w_idle_free;

   always_ff @(posedge CLK) begin
      if (CE) begin
         if (!RESn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (w_act && (WS != '0)) begin
                     r_state <= S_WAIT;
                     r_cnt   <= WS - WSW'(1);
                  end
               end
               S_WAIT: begin
                  if (!w_act || (r_cnt == '0))
                     r_state <= S_IDLE;
                  else
                     r_cnt   <= r_cnt - WSW'(1);
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (CE) begin
         if (!RESn)
            r_bus16 <= BUS16_RST;
         else if (BUS16_SET && w_idle_free)
            r_bus16 <= BUS16_VAL;
      end
   end

   always_ff @(posedge CLK) begin
      if (CE) begin
         if (!RESn)
            r_bcy_cnt <= '0;
         else if (!BCYSTn)
            r_bcy_cnt <= r_bcy_cnt + 16'd1;
      end
   end

   // Bus writes take priority; preload is only accepted when the bus is quiet.
   always_ff @(posedge CLK) begin
      if (CE) begin
         if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
               if (w_wbe[i])
                  r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
            end
         end else if (w_pwe) begin
            r_mem[PA] <= PD_I;
         end
      end
   end

   assign PD_O = r_mem[PA];

`ifdef V810_BUS_RAM_RANGECHK_EN
   logic r_err;
   always_ff @(posedge CLK) begin
      if (CE) begin
         if (!RESn)
            r_err <= 1'b0;
         else if (w_rdy && w_oor)
            r_err <= 1'b1;
      end
   end
   assign ERR = r_err;
`else
   assign ERR = 1'b0;
`endif

endmodule
